// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_types (package)
//  Description : Shared types and constants for the RV32I pipeline control
//                logic: the 2-bit stall-controller state and the canonical
//                NOP instruction (addi x0, x0, 0).
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,   // pipeline flowing
        ST_WAIT_BOTH = 2'd1,   // fetch and data responses both outstanding
        ST_WAIT_I    = 2'd2,   // data side done, fetch outstanding
        ST_WAIT_D    = 2'd3    // fetch side done, data outstanding
    } ctrl_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage : rv32i_types
`default_nettype wire

// File: rtl/sat_counter32.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter32
//  Description : 32-bit event counter that sticks at all-ones instead of
//                wrapping. Synchronous clear has priority over increment.
//  Ports       : clk    - clock
//                rst_n  - asynchronous active-low reset
//                inc_i  - count one event this cycle
//                clr_i  - synchronous clear
//                cnt_o  - current count
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_i,
    input  logic        clr_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 32'd0;
        end else if (inc_i && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sat_counter32
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl
//  Description : Stall/flush controller for a 5-stage RV32I pipeline with
//                variable-latency instruction and data memories. The whole
//                pipeline advances only when both the fetch response and (if a
//                load/store is in MEM) the data response have been seen. A
//                response that arrives early is parked in a hold register and
//                replayed on inst_out/load_data in the advancing cycle.
//  Ports       : clk, rst (async, active-low)
//                imem_resp/imem_rdata  - fetch response pulse and data
//                dmem_req              - MEM stage holds a valid load/store
//                dmem_resp/dmem_rdata  - data response pulse and data
//                load_use, br_taken    - hazard / redirect requests
//                imem_req, *_we        - pipeline register enables
//                if_id_flush, id_ex_bubble - squash controls
//                inst_out, load_data   - muxed fetch / load data
//                stall_cnt, flush_cnt  - saturating event counters
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    input  logic        dmem_req,
    input  logic        dmem_resp,
    input  logic [31:0] dmem_rdata,
    input  logic        load_use,
    input  logic        br_taken,
    output logic        imem_req,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        id_ex_we,
    output logic        ex_mem_we,
    output logic        mem_wb_we,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic [31:0] inst_out,
    output logic [31:0] load_data,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    ctrl_state_t state_q, state_d;
    logic        active_q;      // reset released and resynchronised to clk
    logic        first_q;       // first active cycle: kick off the initial fetch
    logic [31:0] hold_i_q, hold_d_q;
    logic        imem_ok, dmem_ok, advance;
    logic        cap_i, cap_d;

    // Reset asserts asynchronously but is released on a clock edge, so the
    // first active cycle is the one after rst rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q <= 1'b0;
            first_q  <= 1'b1;
        end else begin
            active_q <= 1'b1;
            if (active_q) begin
                first_q <= 1'b0;
            end
        end
    end

    // Which side is satisfied this cycle, depending on what is still owed.
    // In the WAIT states dmem_req is ignored: MEM is frozen.
    always_comb begin
        imem_ok = imem_resp;
        dmem_ok = !dmem_req || dmem_resp;
        case (state_q)
            ST_WAIT_BOTH: dmem_ok = dmem_resp;
            ST_WAIT_I:    dmem_ok = 1'b1;
            ST_WAIT_D: begin
                imem_ok = 1'b1;
                dmem_ok = dmem_resp;
            end
            default: ;
        endcase
    end

    assign advance = active_q && imem_ok && dmem_ok;

    // Only RUN/WAIT_BOTH can still be owed either response; a duplicate pulse
    // for an already-satisfied side must not overwrite the parked value.
    assign cap_i = active_q && !advance && imem_resp &&
                   ((state_q == ST_RUN) || (state_q == ST_WAIT_BOTH));
    assign cap_d = active_q && !advance && dmem_resp &&
                   ((state_q == ST_RUN) || (state_q == ST_WAIT_BOTH));

    always_comb begin
        state_d = state_q;
        if (advance) begin
            state_d = ST_RUN;
        end else if (active_q &&
                     ((state_q == ST_RUN) || (state_q == ST_WAIT_BOTH))) begin
            case ({imem_ok, dmem_ok})
                2'b00:   state_d = ST_WAIT_BOTH;
                2'b01:   state_d = ST_WAIT_I;
                2'b10:   state_d = ST_WAIT_D;
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            hold_i_q <= 32'd0;
            hold_d_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (cap_i) hold_i_q <= imem_rdata;
            if (cap_d) hold_d_q <= dmem_rdata;
        end
    end

    assign inst_out  = (state_q == ST_WAIT_D) ? hold_i_q : imem_rdata;
    assign load_data = (state_q == ST_WAIT_I) ? hold_d_q : dmem_rdata;

    // Pipeline enables. Everything freezes when not advancing; a taken
    // branch outranks a load-use hazard.
    always_comb begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_we     = 1'b0;
        ex_mem_we    = 1'b0;
        mem_wb_we    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (advance) begin
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
            mem_wb_we = 1'b1;
            if (br_taken) begin
                pc_we        = 1'b1;
                if_id_we     = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (load_use) begin
                id_ex_bubble = 1'b1;
            end else begin
                pc_we    = 1'b1;
                if_id_we = 1'b1;
            end
        end
    end

    assign imem_req = active_q && (first_q || pc_we);

    sat_counter32 u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc_i (active_q && (!advance || (load_use && !br_taken))),
        .clr_i (!active_q),
        .cnt_o (stall_cnt)
    );

    sat_counter32 u_flush_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc_i (advance && br_taken),
        .clr_i (!active_q),
        .cnt_o (flush_cnt)
    );

endmodule : pipeline_ctrl
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_ctrl
//  Description : Self-checking bench for pipeline_ctrl. A transaction-level
//                model tracks, per stall window, whether the fetch and data
//                sides have been satisfied and which values were parked, and
//                predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_resp = 1'b0, dmem_req = 1'b0, dmem_resp = 1'b0;
    logic        load_use = 1'b0, br_taken = 1'b0;
    logic [31:0] imem_rdata = 32'd0, dmem_rdata = 32'd0;
    logic        imem_req, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic        if_id_flush, id_ex_bubble;
    logic [31:0] inst_out, load_data, stall_cnt, flush_cnt;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic        m_win;        // inside a stall window
    logic        m_got_i;      // fetch already satisfied in this window
    logic        m_dsat;       // data side already satisfied in this window
    logic [31:0] m_hold_i, m_hold_d;
    logic [31:0] m_stall, m_flush;
    logic        m_first;
    logic        dir_ld_en = 1'b0;
    logic [31:0] dir_ld    = 32'd0;

    pipeline_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .dmem_req     (dmem_req),
        .dmem_resp    (dmem_resp),
        .dmem_rdata   (dmem_rdata),
        .load_use     (load_use),
        .br_taken     (br_taken),
        .imem_req     (imem_req),
        .pc_we        (pc_we),
        .if_id_we     (if_id_we),
        .id_ex_we     (id_ex_we),
        .ex_mem_we    (ex_mem_we),
        .mem_wb_we    (mem_wb_we),
        .if_id_flush  (if_id_flush),
        .id_ex_bubble (id_ex_bubble),
        .inst_out     (inst_out),
        .load_data    (load_data),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One cycle: drive at the negedge, check mid-low-phase, advance the model,
    // then wait for the next negedge.
    task automatic step(input logic ir, input logic [31:0] ird, input logic dq,
                        input logic dr, input logic [31:0] drd,
                        input logic lu, input logic bt);
        logic        gi, gd, adv, e_pc, e_ifid, e_fl, e_bub;
        logic [31:0] e_inst, e_ld;
        imem_resp = ir; imem_rdata = ird; dmem_req = dq;
        dmem_resp = dr; dmem_rdata = drd; load_use = lu; br_taken = bt;
        #1;
        gi  = (m_win && m_got_i) || ir;
        gd  = m_win ? (m_dsat || dr) : (!dq || dr);
        adv = gi && gd;
        e_inst = (m_win && m_got_i) ? m_hold_i : ird;
        e_ld   = (m_win && m_dsat)  ? m_hold_d : drd;
        e_pc   = adv && (bt || !lu);
        e_ifid = e_pc;
        e_fl   = adv && bt;
        e_bub  = adv && (bt || lu);
        chk("pc_we",        {31'd0, pc_we},        {31'd0, e_pc});
        chk("if_id_we",     {31'd0, if_id_we},     {31'd0, e_ifid});
        chk("id_ex_we",     {31'd0, id_ex_we},     {31'd0, adv});
        chk("ex_mem_we",    {31'd0, ex_mem_we},    {31'd0, adv});
        chk("mem_wb_we",    {31'd0, mem_wb_we},    {31'd0, adv});
        chk("if_id_flush",  {31'd0, if_id_flush},  {31'd0, e_fl});
        chk("id_ex_bubble", {31'd0, id_ex_bubble}, {31'd0, e_bub});
        chk("imem_req",     {31'd0, imem_req},     {31'd0, (m_first || e_pc)});
        chk("inst_out",     inst_out,  e_inst);
        chk("load_data",    load_data, e_ld);
        chk("stall_cnt",    stall_cnt, m_stall);
        chk("flush_cnt",    flush_cnt, m_flush);
        if (dir_ld_en) chk("directed_load", load_data, dir_ld);
        if (adv) begin
            m_win = 1'b0;
        end else begin
            if (ir && !(m_win && m_got_i)) m_hold_i = ird;
            if (dr && !(m_win && m_dsat))  m_hold_d = drd;
            m_got_i = gi;
            m_dsat  = gd;
            m_win   = 1'b1;
        end
        if ((!adv || (lu && !bt)) && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
        if (adv && bt && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 32'd1;
        m_first = 1'b0;
        @(negedge clk);
    endtask

    // Assert reset mid-cycle with inputs that would otherwise advance.
    task automatic do_reset();
        imem_resp = 1'b1; dmem_req = 1'b1; dmem_resp = 1'b1;
        load_use = 1'b0; br_taken = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_pc_we",    {31'd0, pc_we},        32'd0);
        chk("rst_we_all",   {28'd0, if_id_we, id_ex_we, ex_mem_we, mem_wb_we}, 32'd0);
        chk("rst_flush",    {31'd0, if_id_flush},  32'd0);
        chk("rst_bubble",   {31'd0, id_ex_bubble}, 32'd0);
        chk("rst_imem_req", {31'd0, imem_req},     32'd0);
        chk("rst_stall",    stall_cnt, 32'd0);
        chk("rst_flushcnt", flush_cnt, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        imem_resp = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0; br_taken = 1'b0;
        #1;
        chk("sync_gap_imem_req", {31'd0, imem_req}, 32'd0);
        chk("sync_gap_pc_we",    {31'd0, pc_we},    32'd0);
        @(negedge clk);
        m_win = 1'b0; m_got_i = 1'b0; m_dsat = 1'b0;
        m_hold_i = 32'd0; m_hold_d = 32'd0;
        m_stall = 32'd0; m_flush = 32'd0; m_first = 1'b1;
    endtask

    initial begin
        logic [31:0] s0, f0;
        @(negedge clk);
        do_reset();

        // Free-running fetch, no memory ops: no stalls
        for (int i = 0; i < 5; i++) step(1'b1, 32'h1000 + i, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("run_no_stall", stall_cnt, 32'd0);

        // Fetch at t0, data at t3; extra imem pulse and dmem_req drop in between
        s0 = m_stall;
        step(1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 32'd0,        1'b0, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0,        1'b0, 1'b0);
        step(1'b0, 32'h1111_2222, 1'b0, 1'b0, 32'd0,        1'b0, 1'b0);
        step(1'b0, 32'h3333_4444, 1'b1, 1'b1, 32'h0BAD_F00D, 1'b0, 1'b0);
        chk("wait_d_stall3", stall_cnt, s0 + 32'd3);

        // Both missing, data at t1, fetch at t2 (with an extra dmem pulse)
        step(1'b0, 32'd0,        1'b1, 1'b0, 32'h5555_5555, 1'b0, 1'b0);
        step(1'b0, 32'd0,        1'b1, 1'b1, 32'hCAFE_0001, 1'b0, 1'b0);
        dir_ld_en = 1'b1; dir_ld = 32'hCAFE_0001;
        step(1'b1, 32'h7777_0000, 1'b0, 1'b1, 32'h9999_9999, 1'b0, 1'b0);
        dir_ld_en = 1'b0;

        // Branch outranks load-use
        s0 = m_stall; f0 = m_flush;
        step(1'b1, 32'h2000, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("br_flush_inc",   flush_cnt, f0 + 32'd1);
        chk("br_stall_same",  stall_cnt, s0);

        // Load-use alone
        s0 = m_stall;
        step(1'b1, 32'h2004, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("lu_stall_inc", stall_cnt, s0 + 32'd1);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) < 6), $urandom, ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 9) < 4), $urandom,
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
        end

        // Reset in the middle of a WAIT_BOTH window
        step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(($urandom_range(0, 9) < 6), $urandom, ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 9) < 4), $urandom,
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pipeline_ctrl
`default_nettype wire

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have ports: clk input 1 clock; rst input 1 reset; one clock, reset is asynchronous and active-low.
REQ-002 SHALL have ports: imem_resp in 1 (one-cycle fetch-response pulse); imem_rdata in 32; dmem_req in 1 (MEM stage holds a valid load/store this cycle); dmem_resp in 1 (one-cycle pulse); dmem_rdata in 32.
REQ-003 SHALL have ports: load_use in 1 (load-use hazard from the stall detector); br_taken in 1 (EX-stage redirect).
REQ-004 SHALL have ports: imem_req out 1; pc_we out 1; if_id_we out 1; id_ex_we out 1; ex_mem_we out 1; mem_wb_we out 1.
REQ-005 SHALL have ports: if_id_flush out 1; id_ex_bubble out 1 (ID/EX loaded with nop 32'h13, valid=0).
REQ-006 SHALL have ports: inst_out out 32; load_data out 32; stall_cnt out 32; flush_cnt out 32.

Function
REQ-007 SHALL implement FSM states RUN, WAIT_BOTH, WAIT_I (data done, fetch pending), WAIT_D (fetch done, data pending).
REQ-008 SHALL compute advance combinationally: RUN = imem_resp && (!dmem_req || dmem_resp); WAIT_BOTH = imem_resp && dmem_resp; WAIT_I = imem_resp; WAIT_D = dmem_resp.
REQ-009 SHALL transition from RUN when !advance to WAIT_BOTH if both are missing, WAIT_I if only imem_resp is missing, and WAIT_D if only dmem_resp is missing.
REQ-010 SHALL transition from WAIT_BOTH to RUN if both responses arrive, to WAIT_D on imem_resp only, and to WAIT_I on dmem_resp only.
REQ-011 SHALL transition from WAIT_I and WAIT_D to RUN on advance, and otherwise hold state.
REQ-012 SHALL capture imem_rdata into a 32-bit hold register on any imem_resp with advance=0, and dmem_rdata likewise into a second hold register.
REQ-013 SHALL drive inst_out = hold in WAIT_D, else imem_rdata; load_data = hold in WAIT_I, else dmem_rdata.
REQ-014 SHALL drive, when advance=0, all *_we, pc_we, if_id_flush, id_ex_bubble = 0 (full freeze; combinational, zero added latency).
REQ-015 SHALL drive, when advance=1, ex_mem_we = mem_wb_we = id_ex_we = 1.
REQ-016 SHALL drive, when advance=1 and br_taken=1: pc_we = 1 (redirect), if_id_we = 1, if_id_flush = 1, id_ex_bubble = 1, with load_use ignored (br_taken priority).
REQ-017 SHALL drive, when advance=1, load_use=1 and br_taken=0: pc_we = 0, if_id_we = 0, id_ex_bubble = 1.
REQ-018 SHALL drive, when advance=1 with neither condition: pc_we = if_id_we = 1 and bubble/flush = 0.
REQ-019 SHALL assert imem_req in the first cycle after reset release and in every cycle where pc_we=1, including the load_use cycle (refetch) only if pc_we=1.
REQ-020 SHALL increment stall_cnt by 1 in each cycle with advance=0 or (advance && load_use && !br_taken), saturating at 32'hFFFF_FFFF.
REQ-021 SHALL increment flush_cnt by 1 on each advance && br_taken, saturating likewise.
REQ-022 SHALL ignore responses arriving for an already-satisfied side in a WAIT state; they SHALL not alter hold registers or state.
REQ-023 SHALL ignore dmem_req changes while in a WAIT state, because the MEM stage is frozen.

Reset
REQ-024 SHALL, on rst low at any time including mid-wait, immediately set state = RUN, hold registers = 0, and counters = 0.
REQ-025 SHALL drive pc_we, all *_we, flush, bubble and imem_req = 0 while rst is low.
REQ-026 SHALL deassert reset synchronously to clk internally, with the first imem_req asserted the cycle after release.

Structure
REQ-027 SHALL define ctrl_state_t (2-bit enum) and the nop constant 32'h13 in rv32i_types.
REQ-028 SHALL implement both counters as two instances of one sub-module sat_counter32 (inc, clr, 32-bit saturating).

Verification
REQ-029 SHALL verify: RUN, imem_resp=1, dmem_req=0 every cycle -> advance each cycle, pc_we=1, stall_cnt stays 0.
REQ-030 SHALL verify: dmem_req=1, imem_resp=1 at t0, dmem_resp at t3 -> WAIT_D t1-t3, inst_out = latched value from t0, advance at t3, stall_cnt=3.
REQ-031 SHALL verify: both missing at t0, dmem_resp t1 (rdata 0xCAFE0001), imem_resp t2 -> WAIT_BOTH -> WAIT_I -> RUN, load_data=0xCAFE0001 at t2.
REQ-032 SHALL verify: load_use=1 and br_taken=1 with advance -> pc_we=1, if_id_flush=1, id_ex_bubble=1, flush_cnt +1, stall_cnt unchanged.
REQ-033 SHALL verify: load_use=1 only -> pc_we=0, if_id_we=0, bubble=1, stall_cnt +1.
REQ-034 SHALL verify: rst low during WAIT_BOTH -> state RUN, counters 0, outputs 0; imem_req=1 one cycle after release.
